// File: rtl/cu_fsm_pkg.sv
// Shared types and constants for the multicycle control unit: state encoding,
// RV32I major opcodes, trap cause codes and an index-width helper.
package cu_fsm_pkg;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    WB    = 3'd3,
    INTR  = 3'd4,
    TRAP  = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_BUS     = 2'b10;

  // A single interrupt line still needs a 1-bit index port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest-index asserted request wins.
// Purely combinational, zero latency; no flow control.
module irq_prio_enc
  import cu_fsm_pkg::*;
#(
  parameter  int NUM_IRQ = 4,
  localparam int IDW     = id_width(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               any,
  output logic [IDW-1:0]     idx
);

  always_comb begin
    any = |req;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = IDW'(i);
    end
  end

endmodule

// File: rtl/cu_fsm_mc.sv
// Multicycle control unit with memory wait states, interrupts and traps.
// Enables follow the current state and ready inputs in the same cycle; waits stall in place up to TIMEOUT.
module cu_fsm_mc
  import cu_fsm_pkg::*;
#(
  parameter  int NUM_IRQ = 4,
  parameter  int TIMEOUT = 15,
  localparam int IDW     = id_width(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               mie,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               PC_WE,
  output logic               RF_WE,
  output logic               memWE2,
  output logic               memRDEN1,
  output logic               memRDEN2,
  output logic               csr_WE,
  output logic               reset,
  output logic               int_taken,
  output logic               mret_exec,
  output logic [IDW-1:0]     int_id,
  output logic               trap_taken,
  output logic [1:0]         trap_cause
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t         state;
  state_t         nxt;
  logic [CW-1:0]  wait_cnt;
  logic [IDW-1:0] int_id_q;
  logic [1:0]     trap_cause_q;
  logic [1:0]     cause_nxt;
  logic           waiting;
  logic           complete;
  logic           timed_out;
  logic           pend_any;
  logic [IDW-1:0] pend_idx;
  logic [NUM_IRQ-1:0] pend;

  assign pend      = irq & irq_en & {NUM_IRQ{mie}};
  assign timed_out = (TIMEOUT > 0) && (wait_cnt == CW'(TIMEOUT));

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .req (pend),
    .any (pend_any),
    .idx (pend_idx)
  );

  always_comb begin
    nxt        = state;
    cause_nxt  = TC_NONE;
    waiting    = 1'b0;
    complete   = 1'b0;
    PC_WE      = 1'b0;
    RF_WE      = 1'b0;
    memWE2     = 1'b0;
    memRDEN1   = 1'b0;
    memRDEN2   = 1'b0;
    csr_WE     = 1'b0;
    reset      = 1'b0;
    int_taken  = 1'b0;
    mret_exec  = 1'b0;
    trap_taken = 1'b0;
    int_id     = '0;
    trap_cause = TC_NONE;

    case (state)
      INIT: begin
        reset = 1'b1;
        nxt   = FETCH;
      end

      FETCH: begin
        memRDEN1 = 1'b1;
        if (imem_ready) begin
          nxt = EXEC;
        end else if (timed_out) begin
          nxt       = TRAP;
          cause_nxt = TC_BUS;
        end else begin
          waiting = 1'b1;
        end
      end

      EXEC: begin
        case (opcode)
          OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
            RF_WE    = 1'b1;
            PC_WE    = 1'b1;
            complete = 1'b1;
          end
          OPC_BRANCH: begin
            PC_WE    = 1'b1;
            complete = 1'b1;
          end
          OPC_SYSTEM: begin
            PC_WE    = 1'b1;
            complete = 1'b1;
            if (funct3 == 3'b000) begin
              mret_exec = 1'b1;
            end else begin
              csr_WE = 1'b1;
              RF_WE  = 1'b1;
            end
          end
          OPC_LOAD: begin
            memRDEN2 = 1'b1;
            nxt      = WB;
          end
          OPC_STORE: begin
            memWE2 = 1'b1;
            if (dmem_ready) begin
              PC_WE    = 1'b1;
              complete = 1'b1;
            end else if (timed_out) begin
              nxt       = TRAP;
              cause_nxt = TC_BUS;
            end else begin
              waiting = 1'b1;
            end
          end
          default: begin
            nxt       = TRAP;
            cause_nxt = TC_ILLEGAL;
          end
        endcase
      end

      WB: begin
        memRDEN2 = 1'b1;
        if (dmem_ready) begin
          RF_WE    = 1'b1;
          PC_WE    = 1'b1;
          complete = 1'b1;
        end else if (timed_out) begin
          nxt       = TRAP;
          cause_nxt = TC_BUS;
        end else begin
          waiting = 1'b1;
        end
      end

      INTR: begin
        PC_WE     = 1'b1;
        int_taken = 1'b1;
        int_id    = int_id_q;
        nxt       = FETCH;
      end

      TRAP: begin
        PC_WE      = 1'b1;
        trap_taken = 1'b1;
        trap_cause = trap_cause_q;
        nxt        = FETCH;
      end

      default: nxt = INIT;
    endcase

    // Interrupts are only considered once the current instruction has retired.
    if (complete) nxt = pend_any ? INTR : FETCH;

    if (RST) begin
      PC_WE      = 1'b0;
      RF_WE      = 1'b0;
      memWE2     = 1'b0;
      memRDEN1   = 1'b0;
      memRDEN2   = 1'b0;
      csr_WE     = 1'b0;
      reset      = 1'b0;
      int_taken  = 1'b0;
      mret_exec  = 1'b0;
      trap_taken = 1'b0;
      int_id     = '0;
      trap_cause = TC_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state        <= INIT;
      wait_cnt     <= '0;
      int_id_q     <= '0;
      trap_cause_q <= TC_NONE;
    end else begin
      state <= nxt;
      // Any cycle that is not a stall ends the wait, which clears on every state entry.
      wait_cnt     <= waiting ? (wait_cnt + CW'(1)) : '0;
      trap_cause_q <= (nxt == TRAP) ? cause_nxt : TC_NONE;
      if (nxt == INTR && state != INTR) int_id_q <= pend_idx;
    end
  end

endmodule
